// File: rtl/sm_pkg.sv
// Op codes and small helpers shared by the sign-magnitude accumulator datapath.
package sm_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_ACC  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  // A zero magnitude always carries a positive sign.
  function automatic logic canon_sign(input logic sign, input logic mag_nz);
    return sign & mag_nz;
  endfunction

  function automatic int unsigned mag_max(input int unsigned mag_w);
    return (32'd1 << mag_w) - 32'd1;
  endfunction

endpackage

// File: rtl/sm_add_core.sv
// Combinational sign-magnitude adder: x + y with overflow flag, saturating or wrapping.
module sm_add_core
  import sm_pkg::*;
#(
  parameter int MAG_W    = 20,
  parameter bit SATURATE = 1'b1
) (
  input  logic [MAG_W:0] x_i,
  input  logic [MAG_W:0] y_i,
  output logic [MAG_W:0] sum_o,
  output logic           ovf_o
);

  localparam logic [MAG_W-1:0] MAX = MAG_W'(mag_max(MAG_W));

  logic [MAG_W-1:0] xm;
  logic [MAG_W-1:0] ym;
  logic [MAG_W-1:0] mag;
  logic [MAG_W:0]   wide;
  logic             sign;
  logic             ovf;

  assign xm   = x_i[MAG_W-1:0];
  assign ym   = y_i[MAG_W-1:0];
  assign wide = {1'b0, xm} + {1'b0, ym};

  always_comb begin
    sign = 1'b0;
    mag  = '0;
    ovf  = 1'b0;
    if (x_i[MAG_W] == y_i[MAG_W]) begin
      sign = x_i[MAG_W];
      ovf  = wide[MAG_W];
      mag  = (ovf && SATURATE) ? MAX : wide[MAG_W-1:0];
    end else if (xm >= ym) begin
      sign = x_i[MAG_W];
      mag  = xm - ym;
    end else begin
      sign = y_i[MAG_W];
      mag  = ym - xm;
    end
  end

  // Canonicalising here also covers equal-magnitude cancellation and wrap to zero.
  assign sum_o = {canon_sign(sign, |mag), mag};
  assign ovf_o = ovf;

endmodule

// File: rtl/sm_pipe_accumulator.sv
// Two-stage sign-magnitude add/sub/accumulate pipeline with valid/ready backpressure,
// saturation and a sticky overflow flag; stage 1 canonicalises, stage 2 computes and updates acc.
module sm_pipe_accumulator
  import sm_pkg::*;
#(
  parameter int MAG_W    = 20,
  parameter bit SATURATE = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [MAG_W:0] in_a,
  input  logic [MAG_W:0] in_b,
  input  logic [1:0]     in_op,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [MAG_W:0] out_sum,
  output logic           out_sat,
  output logic           sat_sticky,
  input  logic           sat_clr
);

  localparam int W = MAG_W + 1;

  logic         s1_valid_q, s1_valid_d;
  logic [W-1:0] s1_a_q, s1_a_d;
  logic [W-1:0] s1_b_q, s1_b_d;
  logic [1:0]   s1_op_q, s1_op_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_sum_q, out_sum_d;
  logic         out_sat_q, out_sat_d;
  logic [W-1:0] acc_q, acc_d;
  logic         sticky_q, sticky_d;

  logic         adv1, adv2, in_fire, s2_load;
  logic         b_sign, s1_is_acc, s1_is_load, ovf, core_ovf;
  logic [W-1:0] core_x, core_y, core_sum, result;

  assign adv2     = !out_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1 && !rst;
  assign in_fire  = in_valid && in_ready;
  assign s2_load  = adv2 && s1_valid_q;

  assign b_sign = in_b[MAG_W] ^ (in_op == OP_SUB);

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    if (adv1) s1_valid_d = in_fire;
    if (in_fire) begin
      s1_a_d  = {canon_sign(in_a[MAG_W], |in_a[MAG_W-1:0]), in_a[MAG_W-1:0]};
      s1_b_d  = {canon_sign(b_sign, |in_b[MAG_W-1:0]), in_b[MAG_W-1:0]};
      s1_op_d = in_op;
    end
  end

  assign s1_is_acc  = (s1_op_q == OP_ACC);
  assign s1_is_load = (s1_op_q == OP_LOAD);
  assign core_x     = s1_is_acc ? acc_q  : s1_a_q;
  assign core_y     = s1_is_acc ? s1_a_q : s1_b_q;

  sm_add_core #(
    .MAG_W    (MAG_W),
    .SATURATE (SATURATE)
  ) u_core (
    .x_i   (core_x),
    .y_i   (core_y),
    .sum_o (core_sum),
    .ovf_o (core_ovf)
  );

  assign result = s1_is_load ? s1_a_q : core_sum;
  assign ovf    = !s1_is_load && core_ovf;

  // acc is written alongside out_sum, so a following ACC already sees the new value.
  always_comb begin
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_sat_d   = out_sat_q;
    acc_d       = acc_q;
    sticky_d    = sticky_q;
    if (adv2) out_valid_d = s1_valid_q;
    if (s2_load) begin
      out_sum_d = result;
      out_sat_d = ovf;
      if (s1_is_acc || s1_is_load) acc_d = result;
    end
    if (s2_load && ovf) sticky_d = 1'b1;
    else if (sat_clr)   sticky_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_op_q     <= OP_ADD;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_sat_q   <= 1'b0;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_op_q     <= s1_op_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_sat_q   <= out_sat_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sum    = out_sum_q;
  assign out_sat    = out_sat_q;
  assign sat_sticky = sticky_q;

endmodule

// File: tb/tb_sm_pipe_accumulator.sv
// Self-checking bench: directed cases plus randomized traffic against a value-level model.
module tb_sm_pipe_accumulator;

  localparam int MAG_W = 20;
  localparam int W     = 21;
  localparam int MAXV  = 1048575;

  localparam logic [1:0] ADD  = 2'b00;
  localparam logic [1:0] SUB  = 2'b01;
  localparam logic [1:0] ACC  = 2'b10;
  localparam logic [1:0] LOAD = 2'b11;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, out_sat, sat_sticky, sat_clr;
  logic [W-1:0] in_a, in_b, out_sum;
  logic [1:0]   in_op;

  sm_pipe_accumulator #(.MAG_W(MAG_W), .SATURATE(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_sat    (out_sat),
    .sat_sticky (sat_sticky),
    .sat_clr    (sat_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         sat;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] got_q[$];
  logic         got_sat_q[$];
  int           acc_m;
  bit           sticky_m;
  bit           chk_sticky;
  bit           rnd_on;
  int           n_chk;
  int           n_err;
  bit           held_v;
  logic [W-1:0] held_sum;
  logic         held_sat;

  task automatic chkw(input string nm, input logic [W-1:0] got, input logic [W-1:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic chkb(input string nm, input logic got, input logic want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got=%b want=%b", nm, got, want);
    end
  endtask

  // Reference: signed integer arithmetic, clamp, then re-encode as sign-magnitude.
  function automatic int sval(input logic [W-1:0] w);
    int m;
    m = int'(w[MAG_W-1:0]);
    return w[MAG_W] ? -m : m;
  endfunction

  function automatic exp_t model_step(input logic [1:0] op, input logic [W-1:0] a,
                                      input logic [W-1:0] b);
    exp_t e;
    int   r;
    case (op)
      ADD:     r = sval(a) + sval(b);
      SUB:     r = sval(a) - sval(b);
      ACC:     r = acc_m + sval(a);
      default: r = sval(a);
    endcase
    e.sat = (r > MAXV) || (r < -MAXV);
    if (r > MAXV)  r = MAXV;
    if (r < -MAXV) r = -MAXV;
    if (op == ACC || op == LOAD) acc_m = r;
    e.sum = (r < 0) ? {1'b1, MAG_W'(-r)} : {1'b0, MAG_W'(r)};
    return e;
  endfunction

  task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (!in_ready) begin
      n_err++;
      $display("FAIL send_accept: in_ready=%b after %0d cycles, want 1", in_ready, n);
    end else begin
      exp_q.push_back(model_step(op, a, b));
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_got(input int n);
    int k;
    k = 0;
    while (got_q.size() < n && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (got_q.size() < n) begin
      n_err++;
      $display("FAIL wait_results: got=%0d results want=%0d", got_q.size(), n);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd_word();
    logic [MAG_W-1:0] m;
    case ($urandom_range(0, 3))
      0:       m = '0;
      1:       m = MAG_W'($urandom_range(1, 20));
      2:       m = MAG_W'(MAXV - int'($urandom_range(0, 20)));
      default: m = MAG_W'($urandom);
    endcase
    return {1'($urandom_range(0, 1)), m};
  endfunction

  // Compare process: every output transfer against the model, plus hold-while-stalled.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      acc_m    = 0;
      sticky_m = 1'b0;
      held_v   = 1'b0;
    end else begin
      if (out_valid && held_v) begin
        chkw("hold_sum", out_sum, held_sum);
        chkb("hold_sat", out_sat, held_sat);
      end
      if (out_valid && out_ready) begin
        held_v = 1'b0;
        got_q.push_back(out_sum);
        got_sat_q.push_back(out_sat);
        n_chk++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_output: got=%h want=none", out_sum);
        end else begin
          e = exp_q.pop_front();
          chkw("out_sum", out_sum, e.sum);
          chkb("out_sat", out_sat, e.sat);
          if (chk_sticky) begin
            sticky_m = sticky_m | e.sat;
            chkb("sticky_model", sat_sticky, sticky_m);
          end
        end
      end else if (out_valid) begin
        held_v   = 1'b1;
        held_sum = out_sum;
        held_sat = out_sat;
      end else begin
        held_v = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_on) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_err = 0; acc_m = 0; sticky_m = 1'b0; held_v = 1'b0;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = ADD;
    out_ready = 1'b1; sat_clr = 1'b0; chk_sticky = 1'b0; rnd_on = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chkb("rst_out_valid", out_valid, 1'b0);
    chkw("rst_out_sum", out_sum, 21'h000000);
    chkb("rst_out_sat", out_sat, 1'b0);
    chkb("rst_sticky", sat_sticky, 1'b0);
    chkb("rst_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chkb("in_ready_after_rst", in_ready, 1'b1);

    // 1: -0 operand, two-cycle latency
    idle(1);
    send(ADD, 21'h000005, 21'h100000);
    @(negedge clk);
    chkb("t1_valid_cycle1", out_valid, 1'b0);
    @(negedge clk);
    chkb("t1_valid_cycle2", out_valid, 1'b1);
    chkw("t1_sum", out_sum, 21'h000005);
    chkb("t1_sat", out_sat, 1'b0);

    // 2: cancellation gives +0, subtraction sign
    idle(2);
    got_q.delete(); got_sat_q.delete();
    send(ADD, 21'h000003, 21'h100003);
    send(SUB, 21'h000002, 21'h000007);
    wait_got(2);
    chkw("t2_zero", got_q[0], 21'h000000);
    chkw("t2_sub", got_q[1], 21'h100005);

    // 3: saturation, sticky, clear, and overflow beating a same-cycle clear
    idle(2);
    got_q.delete(); got_sat_q.delete();
    send(ADD, 21'h0FFFFF, 21'h000001);
    wait_got(1);
    chkw("t3_pos_sat_sum", got_q[0], 21'h0FFFFF);
    chkb("t3_pos_sat_flag", got_sat_q[0], 1'b1);
    chkb("t3_sticky_set", sat_sticky, 1'b1);
    idle(1);
    sat_clr = 1'b1;
    idle(1);
    sat_clr = 1'b0;
    @(negedge clk);
    chkb("t3_sticky_clr", sat_sticky, 1'b0);
    idle(1);
    send(ADD, 21'h1FFFFF, 21'h1FFFFF);
    wait_got(2);
    chkw("t3_neg_sat_sum", got_q[1], 21'h1FFFFF);
    chkb("t3_neg_sat_flag", got_sat_q[1], 1'b1);
    chkb("t3_sticky_again", sat_sticky, 1'b1);
    idle(1);
    sat_clr = 1'b1;
    send(ADD, 21'h0FFFFF, 21'h0FFFFF);
    @(negedge clk);
    chkb("t3_clr_no_ovf", sat_sticky, 1'b0);
    @(negedge clk);
    chkb("t3_ovf_wins_clr", sat_sticky, 1'b1);
    idle(1);
    sat_clr = 1'b0;

    // 4: back-to-back accumulate
    idle(2);
    got_q.delete(); got_sat_q.delete();
    send(LOAD, 21'h00000A, 21'h000000);
    send(ACC,  21'h100004, 21'h000000);
    send(ACC,  21'h100006, 21'h000000);
    send(ACC,  21'h100001, 21'h000000);
    wait_got(4);
    chkw("t4_load", got_q[0], 21'h00000A);
    chkw("t4_acc1", got_q[1], 21'h000006);
    chkw("t4_acc2", got_q[2], 21'h000000);
    chkw("t4_acc3", got_q[3], 21'h100001);

    // 5: stall holds two words, then drains in order
    idle(2);
    got_q.delete(); got_sat_q.delete();
    out_ready = 1'b0;
    send(ADD, 21'h000001, 21'h000001);
    send(ADD, 21'h000002, 21'h000002);
    @(negedge clk);
    chkb("t5_in_ready_stalled", in_ready, 1'b0);
    chkw("t5_held_front", out_sum, 21'h000002);
    fork
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join_none
    send(ADD, 21'h000003, 21'h000003);
    send(ADD, 21'h000004, 21'h000004);
    wait_got(4);
    chkw("t5_r0", got_q[0], 21'h000002);
    chkw("t5_r1", got_q[1], 21'h000004);
    chkw("t5_r2", got_q[2], 21'h000006);
    chkw("t5_r3", got_q[3], 21'h000008);

    // 6: reset mid-stream discards in-flight words and clears acc
    idle(2);
    out_ready = 1'b0;
    send(LOAD, 21'h000007, 21'h000000);
    send(ADD, 21'h0FFFFF, 21'h0FFFFF);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    got_q.delete(); got_sat_q.delete();
    @(negedge clk);
    chkb("t6_valid_after_rst", out_valid, 1'b0);
    chkb("t6_sticky_after_rst", sat_sticky, 1'b0);
    chkw("t6_sum_after_rst", out_sum, 21'h000000);
    idle(1);
    out_ready = 1'b1;
    send(ACC, 21'h000002, 21'h000000);
    wait_got(1);
    idle(4);
    n_chk++;
    if (got_q.size() != 1) begin
      n_err++;
      $display("FAIL t6_result_count: got=%0d want=1", got_q.size());
    end
    chkw("t6_acc_from_zero", got_q[0], 21'h000002);

    // Randomized traffic with random backpressure
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk_sticky = 1'b1;
    rnd_on = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      send(2'($urandom_range(0, 3)), rnd_word(), rnd_word());
    end
    rnd_on = 1'b0;
    out_ready = 1'b1;
    begin
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 100) begin
        @(negedge clk);
        k++;
      end
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: outstanding=%0d want=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
